// File: rtl/contador_sinc.sv
// Modulo-MOD synchronous counter with saturating parallel load, built from per-bit ffd cells.
// Define CONTADOR_DOWN_EN to add the 'up' direction port and down counting.

module ffd (
   input  logic clk,
   input  logic d,
   input  logic pr,
   input  logic clr,
   output logic q
);

   // NOTE: flops use non-blocking assignments so every cell samples its pre-edge inputs.
   always_ff @(posedge clk or posedge clr or posedge pr) begin
      if (clr)
         q <= 1'b0;
      else if (pr)
         q <= 1'b1;
      else
         q <= d;
   end

endmodule

module contador_sinc #(
   parameter int WIDTH = 4,
   parameter int MOD   = 10
) (
   input  logic             clk,
   input  logic             clrn,
   input  logic             en,
   input  logic             load,
   input  logic [WIDTH-1:0] d,
`ifdef CONTADOR_DOWN_EN
   input  logic             up,
`endif
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] qn,
   output logic             tc
);

   // Compare in WIDTH+1 bits so MOD = 2^WIDTH stays representable.
   localparam logic [WIDTH-1:0] Q_MAX   = WIDTH'(MOD - 1);
   localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MOD);

   logic             count_up;
   logic             q_oor;
   logic             d_oor;
   logic [WIDTH-1:0] q_next;

`ifdef CONTADOR_DOWN_EN
   assign count_up = up;
`else
   assign count_up = 1'b1;
`endif

   assign q_oor = {1'b0, q} >= MOD_EXT;
   assign d_oor = {1'b0, d} >= MOD_EXT;

   always_comb begin
      // NOTE: default first so every path assigns q_next and no latch is inferred.
      q_next = q;
      if (load) begin
         q_next = d_oor ? Q_MAX : d;
      end else if (en) begin
         if (q_oor)
            q_next = '0;
         else if (count_up)
            q_next = (q == Q_MAX) ? '0 : q + WIDTH'(1);
         else
            q_next = (q == '0) ? Q_MAX : q - WIDTH'(1);
      end
   end

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      ffd u_ffd (
         .clk (clk),
         .d   (q_next[i]),
         .pr  (1'b0),
         .clr (~clrn),
         .q   (q[i])
      );
   end

   assign qn = ~q;
   assign tc = en & (count_up ? (q == Q_MAX) : (q == '0));

endmodule

// File: tb/tb_contador_sinc.sv
// Scoreboard bench for contador_sinc: DUT A is MOD=10, DUT B is MOD=16.
// Down-count vectors are exercised only when CONTADOR_DOWN_EN is defined.

module tb_contador_sinc;

`ifdef CONTADOR_DOWN_EN
   localparam bit DOWN = 1'b1;
`else
   localparam bit DOWN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       clrn;
   logic       strobe = 1'b0;
   logic       a_en, a_load, b_en, b_load;
   logic [3:0] a_d, b_d;
   logic [3:0] a_q, a_qn, b_q, b_qn;
   logic       a_tc, b_tc;
`ifdef CONTADOR_DOWN_EN
   logic       a_up, b_up;
`endif

   typedef struct {
      string      nm;
      bit         sel;
      logic [3:0] q;
      bit         tc;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   contador_sinc #(.WIDTH(4), .MOD(10)) u_dut_a (
      .clk  (clk),
      .clrn (clrn),
      .en   (a_en),
      .load (a_load),
      .d    (a_d),
`ifdef CONTADOR_DOWN_EN
      .up   (a_up),
`endif
      .q    (a_q),
      .qn   (a_qn),
      .tc   (a_tc)
   );

   contador_sinc #(.WIDTH(4), .MOD(16)) u_dut_b (
      .clk  (clk),
      .clrn (clrn),
      .en   (b_en),
      .load (b_load),
      .d    (b_d),
`ifdef CONTADOR_DOWN_EN
      .up   (b_up),
`endif
      .q    (b_q),
      .qn   (b_qn),
      .tc   (b_tc)
   );

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic push(input bit sel, input logic [3:0] eq, input bit etc, input string nm);
      exp_t e;
      e.nm  = nm;
      e.sel = sel;
      e.q   = eq;
      e.tc  = etc;
      sb.push_back(e);
   endtask

   // Drive one vector away from the edge, then queue the state expected just after it.
   task automatic step(input bit sel, input bit c, input bit ld, input logic [3:0] dv,
                       input bit e, input bit u, input logic [3:0] eq, input bit etc,
                       input string nm);
      @(negedge clk);
      clrn = c;
      if (sel == 1'b0) begin
         a_load = ld;
         a_d    = dv;
         a_en   = e;
`ifdef CONTADOR_DOWN_EN
         a_up   = u;
`endif
      end else begin
         b_load = ld;
         b_d    = dv;
         b_en   = e;
`ifdef CONTADOR_DOWN_EN
         b_up   = u;
`endif
      end
      @(posedge clk);
      #1;
      push(sel, eq, etc, nm);
   endtask

   task automatic pulse_strobe();
      strobe = 1'b1;
      #1;
      strobe = 1'b0;
   endtask

   // Monitor: compares queued expectations after each edge or an explicit mid-cycle strobe.
   initial begin
      exp_t       e;
      logic [3:0] qn_exp;
      forever begin
         @(posedge clk or posedge strobe);
         #2;
         while (sb.size() > 0) begin
            e      = sb.pop_front();
            qn_exp = ~e.q;
            if (e.sel == 1'b0) begin
               check({e.nm, " q"},  a_q,  e.q);
               check({e.nm, " qn"}, a_qn, qn_exp);
               check({e.nm, " tc"}, a_tc, e.tc);
            end else begin
               check({e.nm, " q"},  b_q,  e.q);
               check({e.nm, " qn"}, b_qn, qn_exp);
               check({e.nm, " tc"}, b_tc, e.tc);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not reach its end");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] eq;
      clrn   = 1'b0;
      a_en   = 1'b1;
      a_load = 1'b0;
      a_d    = 4'h0;
      b_en   = 1'b0;
      b_load = 1'b0;
      b_d    = 4'h0;
`ifdef CONTADOR_DOWN_EN
      a_up   = 1'b0;
      b_up   = 1'b1;
`endif
      #2;
      push(1'b0, 4'h0, DOWN, "reset A");
      push(1'b1, 4'h0, 1'b0, "reset B");
      pulse_strobe();

      // Up count from reset: 1..9,0,1,2 with tc only at 9.
      for (int i = 1; i <= 12; i++) begin
         eq = 4'(i % 10);
         step(1'b0, 1'b1, 1'b0, 4'h0, 1'b1, 1'b1, eq, eq == 4'd9, $sformatf("up %0d", i));
      end

      step(1'b0, 1'b1, 1'b1, 4'hC, 1'b0, 1'b1, 4'd9, 1'b0, "load sat C");
      step(1'b0, 1'b1, 1'b1, 4'h3, 1'b1, 1'b1, 4'd3, 1'b0, "load beats en");
      step(1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 4'd3, 1'b0, "hold");
      step(1'b0, 1'b1, 1'b1, 4'h9, 1'b0, 1'b1, 4'd9, 1'b0, "load 9");
      step(1'b0, 1'b1, 1'b1, 4'hA, 1'b0, 1'b1, 4'd9, 1'b0, "load sat A");
      step(1'b0, 1'b1, 1'b1, 4'h0, 1'b0, 1'b1, 4'd0, 1'b0, "load 0");

`ifdef CONTADOR_DOWN_EN
      step(1'b0, 1'b1, 1'b1, 4'h1, 1'b0, 1'b0, 4'd1, 1'b0, "dn load 1");
      step(1'b0, 1'b1, 1'b0, 4'h0, 1'b1, 1'b0, 4'd0, 1'b1, "dn 0");
      step(1'b0, 1'b1, 1'b0, 4'h0, 1'b1, 1'b0, 4'd9, 1'b0, "dn 9");
      step(1'b0, 1'b1, 1'b0, 4'h0, 1'b1, 1'b0, 4'd8, 1'b0, "dn 8");
      step(1'b0, 1'b1, 1'b0, 4'h0, 1'b1, 1'b1, 4'd9, 1'b1, "dir up");
      step(1'b0, 1'b1, 1'b0, 4'h0, 1'b1, 1'b0, 4'd8, 1'b0, "dir down");
`endif

      // Asynchronous clear between edges while counting at 7.
      step(1'b0, 1'b1, 1'b1, 4'h6, 1'b0, 1'b1, 4'd6, 1'b0, "load 6");
      step(1'b0, 1'b1, 1'b0, 4'h0, 1'b1, 1'b1, 4'd7, 1'b0, "count 7");
      @(negedge clk);
      #1;
      clrn = 1'b0;
      #1;
      push(1'b0, 4'h0, 1'b0, "async clr");
      pulse_strobe();
      step(1'b0, 1'b0, 1'b1, 4'h5, 1'b1, 1'b1, 4'd0, 1'b0, "clr beats load");
      step(1'b0, 1'b1, 1'b1, 4'h5, 1'b1, 1'b1, 4'd5, 1'b0, "first edge after clr");

      // Full-range modulus (2^WIDTH) wrap from 15 to 0.
      step(1'b1, 1'b1, 1'b1, 4'hF, 1'b1, 1'b1, 4'd15, 1'b1, "B load F");
      step(1'b1, 1'b1, 1'b0, 4'h0, 1'b1, 1'b1, 4'd0,  1'b0, "B wrap");
      step(1'b1, 1'b1, 1'b1, 4'hF, 1'b0, 1'b1, 4'd15, 1'b0, "B load F en0");
      step(1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 4'd15, 1'b0, "B hold");

      repeat (3) @(posedge clk);
      #4;
      check("scoreboard drained", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/contador_sinc.md
CONTADOR_SINC -- requirements
Module: contador_sinc

Interface
REQ-001 Parameter WIDTH, default 4: counter width in bits.
REQ-002 Parameter MOD, default 10: count modulus; legal range 2..2^WIDTH.
REQ-003 clk  input  1  clock; all state changes on the rising edge.
REQ-004 clrn  input  1  reset, asynchronous, active-low; drives q to 0 immediately.
REQ-005 en  input  1  count enable; sampled on the rising clk edge.
REQ-006 load  input  1  synchronous parallel load; sampled on the rising clk edge.
REQ-007 d  input  WIDTH  parallel load value.
REQ-008 up  input  1  direction, 1=up, 0=down; present only with CONTADOR_DOWN_EN.
REQ-009 q  output  WIDTH  registered count value.
REQ-010 qn  output  WIDTH  bitwise complement of q.
REQ-011 tc  output  1  terminal count, combinational, for cascading the next stage.

Function
REQ-012 Each bit of q SHALL be held in an instance of the team ffd cell, with pr tied to 0, clr driven by ~clrn, and next-state logic feeding d.
REQ-013 Per-edge priority SHALL be load, then en, then hold.
REQ-014 When load=1 and d<MOD, q SHALL take the value d on the edge.
REQ-015 When load=1 and d>=MOD, q SHALL take the value MOD-1 on the edge (saturating load).
REQ-016 When load=0, en=1 and counting up, q SHALL become q+1, except that q=MOD-1 wraps to 0.
REQ-017 When load=0, en=1 and counting down, q SHALL become q-1, except that q=0 wraps to MOD-1.
REQ-018 When load=0 and en=0, q SHALL hold its value.
REQ-019 Latency SHALL be one edge: q reflects load or count after the same rising edge, with no extra pipeline stage.
REQ-020 tc SHALL equal en AND ((counting up AND q=MOD-1) OR (counting down AND q=0)); tc is independent of load.
REQ-021 qn SHALL equal ~q at all times, including during reset.
REQ-022 If q ever holds a value >= MOD (unreachable in normal operation), the next enabled count edge SHALL force q to 0.
REQ-023 A change on up SHALL take effect at the next edge; no dead cycle occurs on a direction change.

Reset
REQ-024 While clrn=0, outputs SHALL be q=0, qn=all ones, and tc=en AND counting down.
REQ-025 clrn assertion SHALL override load and en without waiting for clk, including mid-count and mid-load.
REQ-026 On clrn deassertion, the first rising edge SHALL act normally per REQ-013.

Configuration
REQ-027 Macro CONTADOR_DOWN_EN defined: the up port exists and REQ-017 and REQ-023 apply.
REQ-028 Macro CONTADOR_DOWN_EN undefined: the up port is absent, counting is up only, and tc = en AND q=MOD-1.

Verification
REQ-029 MOD=10, reset, en=1 up=1 for 12 edges -> q 1..9,0,1,2; tc=1 only while q=9.
REQ-030 MOD=10, load=1 d=4'hC -> q=9 after the edge; load=1 d=3 with en=1 on the same edge -> q=3.
REQ-031 MOD=10, down mode, q=1, en=1 for 3 edges -> q=0,9,8; tc=1 while q=0.
REQ-032 q=7 counting, clrn pulsed low between edges -> q=0 and qn=4'hF immediately, before any clk edge.
REQ-033 MOD=16, en=1 up=1 from q=15 -> q=0 next edge; en=0 -> q holds and tc=0.
REQ-034 CONTADOR_DOWN_EN undefined, MOD=10, en=1 from q=9 -> q=0; tc=1 at q=9 only.
